if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_in  input  16  instruction word from instruction memory.
REQ-005 pc2_in  input  16  PC+2 of the fetched word.
REQ-006 in_valid  input  1  instr_in/pc2_in valid this cycle (memory done).
REQ-007 id_stall  input  1  decode stage cannot accept the word this cycle.
REQ-008 flush  input  1  taken branch/jump; discard all buffered words.
REQ-009 instruct  output  16  word presented to decode and the immediate extender.
REQ-010 pc2_out  output  16  PC+2 paired with instruct.
REQ-011 valid  output  1  instruct holds a real fetched word.
REQ-012 fetch_stall  output  1  fetch must not present a new word; PC must hold.
REQ-013 err  output  1  protocol violation flag.

Function
REQ-014 Storage SHALL be a main entry (instr + pc2) and one skid entry (instr + pc2).
REQ-015 States SHALL be EMPTY, FULL, SKID (main and skid both occupied).
REQ-016 A word is consumed on a rising edge where valid=1 and id_stall=0.
REQ-017 EMPTY: in_valid=1 -> main<=input, go FULL; else stay EMPTY.
REQ-018 FULL, id_stall=0: in_valid=1 -> main<=input, stay FULL; else go EMPTY.
REQ-019 FULL, id_stall=1: in_valid=1 -> skid<=input, go SKID; else hold.
REQ-020 SKID, id_stall=0: main<=skid, go FULL; in_valid is ignored.
REQ-021 SKID, id_stall=1: hold both entries.
REQ-022 flush=1 SHALL take priority over all other inputs: go EMPTY and discard main, skid and any same-cycle in_valid word.
REQ-023 valid SHALL be 1 in FULL and SKID and 0 in EMPTY, driven from state only.
REQ-024 When valid=0, instruct SHALL be NOP 16'h0800 and pc2_out SHALL be 16'h0000.
REQ-025 When valid=1, instruct and pc2_out SHALL drive the main entry.
REQ-026 fetch_stall SHALL be 1 exactly in state SKID, driven from state only.
REQ-027 err SHALL be combinational in_valid & fetch_stall & ~flush; the word is dropped.
REQ-028 Latency SHALL be one cycle: a word accepted at edge N appears on instruct after edge N.
REQ-029 Words SHALL leave in fetch order, with no loss or duplication except on flush.

Reset
REQ-030 On rst, the block SHALL asynchronously go EMPTY and clear main and skid to 16'h0000.
REQ-031 During reset: instruct=16'h0800, pc2_out=0, valid=0, fetch_stall=0, err=0 unless in_valid is asserted.
REQ-032 On reset deassertion, the first edge with in_valid=1 SHALL load main.

Structure
REQ-033 A shared package SHALL hold the NOP constant 16'h0800 and the 2-bit state encoding: EMPTY=0, FULL=1, SKID=2.
REQ-034 State value 3 SHALL be unreachable; if entered, the block SHALL go to EMPTY on the next edge.
REQ-035 A single sub-module reg16_en SHALL be used: a 16-bit register with enable and async active-high clear.
REQ-036 reg16_en SHALL be instantiated four times: main instr, main pc2, skid instr, skid pc2.

Verification
REQ-037 Reset, then in_valid with instr 16'h4123 and pc2 16'h0002, id_stall=0 -> next cycle valid=1, instruct=16'h4123, pc2_out=16'h0002.
REQ-038 FULL with main 16'hA001; id_stall=1 and in_valid with 16'hA002 -> SKID, fetch_stall=1, instruct stays 16'hA001. Release id_stall -> instruct=16'hA002, fetch_stall=0.
REQ-039 SKID state, flush=1 with in_valid=1 -> next cycle valid=0, instruct=16'h0800, fetch_stall=0.
REQ-040 Back-to-back in_valid for 8 cycles with id_stall=0 -> instruct sequence matches input order with one-cycle lag and no bubbles.
REQ-041 SKID state, id_stall=1 and in_valid=1 -> err=1 that cycle; contents unchanged.
REQ-042 Assert rst mid-stream while in SKID -> outputs immediately reset values without a clock edge.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared constants and state encoding for the IF/ID skid buffer.
package if_id_buffer_pkg;

  localparam logic [15:0] Nop = 16'h0800;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

endpackage

// File: rtl/if_id_buffer_reg16_en.sv
// 16-bit register with load enable and asynchronous active-high clear.
module reg16_en (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 16'h0000;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: one main entry plus one skid entry so fetch can
// complete a word while decode is stalled.
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc2_in,
  input  logic        in_valid,
  input  logic        id_stall,
  input  logic        flush,
  output logic [15:0] instruct,
  output logic [15:0] pc2_out,
  output logic        valid,
  output logic        fetch_stall,
  output logic        err
);

  state_e      state_q, state_d;
  logic        main_en, skid_en, main_from_skid;
  logic [15:0] main_instr_q, main_pc2_q, skid_instr_q, skid_pc2_q;
  logic [15:0] main_instr_d, main_pc2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Contents need not be cleared: outputs are masked while EMPTY.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_valid) begin
            main_en = 1'b1;
            state_d = StFull;
          end
        end
        StFull: begin
          if (!id_stall) begin
            if (in_valid) begin
              main_en = 1'b1;
            end else begin
              state_d = StEmpty;
            end
          end else if (in_valid) begin
            skid_en = 1'b1;
            state_d = StSkid;
          end
        end
        StSkid: begin
          if (!id_stall) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  assign main_instr_d = main_from_skid ? skid_instr_q : instr_in;
  assign main_pc2_d   = main_from_skid ? skid_pc2_q   : pc2_in;

  reg16_en u_main_instr (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_instr_d),
    .q   (main_instr_q)
  );

  reg16_en u_main_pc2 (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_pc2_d),
    .q   (main_pc2_q)
  );

  reg16_en u_skid_instr (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (instr_in),
    .q   (skid_instr_q)
  );

  reg16_en u_skid_pc2 (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (pc2_in),
    .q   (skid_pc2_q)
  );

  assign valid       = (state_q == StFull) || (state_q == StSkid);
  assign fetch_stall = (state_q == StSkid);
  assign instruct    = valid ? main_instr_q : Nop;
  assign pc2_out     = valid ? main_pc2_q : 16'h0000;
  // A word arriving while the skid is occupied is dropped and flagged.
  assign err         = in_valid & fetch_stall & ~flush;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer with a queue-based reference model.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in, pc2_in;
  logic        in_valid, id_stall, flush;
  logic [15:0] instruct, pc2_out;
  logic        valid, fetch_stall, err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } word_t;

  word_t mq[$];

  if_id_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .pc2_in      (pc2_in),
    .in_valid    (in_valid),
    .id_stall    (id_stall),
    .flush       (flush),
    .instruct    (instruct),
    .pc2_out     (pc2_out),
    .valid       (valid),
    .fetch_stall (fetch_stall),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Drive one cycle, check err combinationally, then clock and compare all
  // outputs against the model queue (front entry = main).
  task automatic cyc(input logic iv, input logic [15:0] ins, input logic [15:0] pc,
                     input logic st, input logic fl, input string tag);
    logic        exp_err, exp_valid, exp_fs;
    logic [15:0] exp_instr, exp_pc2;
    word_t       w;
    in_valid = iv; instr_in = ins; pc2_in = pc; id_stall = st; flush = fl;
    #1;
    exp_err = iv && (mq.size() == 2) && !fl;
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", tag, err, exp_err);
    end
    w.instr = ins;
    w.pc2   = pc;
    if (fl) begin
      mq.delete();
    end else begin
      case (mq.size())
        0: if (iv) mq.push_back(w);
        1: begin
          if (!st) begin
            mq.delete(0);
            if (iv) mq.push_back(w);
          end else if (iv) begin
            mq.push_back(w);
          end
        end
        default: if (!st) mq.delete(0);
      endcase
    end
    @(posedge clk);
    #1;
    exp_valid = (mq.size() != 0);
    exp_fs    = (mq.size() == 2);
    exp_instr = exp_valid ? mq[0].instr : 16'h0800;
    exp_pc2   = exp_valid ? mq[0].pc2 : 16'h0000;
    checks++;
    if (valid !== exp_valid || fetch_stall !== exp_fs || instruct !== exp_instr ||
        pc2_out !== exp_pc2) begin
      errors++;
      $display("FAIL %s outputs: got v=%b fs=%b i=%h p=%h want v=%b fs=%b i=%h p=%h", tag,
               valid, fetch_stall, instruct, pc2_out, exp_valid, exp_fs, exp_instr, exp_pc2);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; instr_in = 16'h0; pc2_in = 16'h0;
    id_stall = 1'b0; flush = 1'b0;
    mq.delete();
    #2;
    checks++;
    if (valid !== 1'b0 || instruct !== 16'h0800 || pc2_out !== 16'h0000 ||
        fetch_stall !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b i=%h p=%h fs=%b e=%b want v=0 i=0800 p=0000 fs=0 e=0",
               valid, instruct, pc2_out, fetch_stall, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_first_word;
    cyc(1'b1, 16'h4123, 16'h0002, 1'b0, 1'b0, "first_load");
    checks++;
    if (valid !== 1'b1 || instruct !== 16'h4123 || pc2_out !== 16'h0002) begin
      errors++;
      $display("FAIL first_word: got v=%b i=%h p=%h want v=1 i=4123 p=0002",
               valid, instruct, pc2_out);
    end
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "first_drain");
  endtask

  task automatic test_skid;
    cyc(1'b1, 16'hA001, 16'h0010, 1'b0, 1'b0, "skid_fill");
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "full_hold");
    cyc(1'b1, 16'hA002, 16'h0012, 1'b1, 1'b0, "skid_enter");
    checks++;
    if (fetch_stall !== 1'b1 || instruct !== 16'hA001) begin
      errors++;
      $display("FAIL skid_enter: got fs=%b i=%h want fs=1 i=a001", fetch_stall, instruct);
    end
    cyc(1'b1, 16'hA003, 16'h0014, 1'b1, 1'b0, "skid_err");
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "skid_release");
    checks++;
    if (fetch_stall !== 1'b0 || instruct !== 16'hA002 || pc2_out !== 16'h0012) begin
      errors++;
      $display("FAIL skid_release: got fs=%b i=%h p=%h want fs=0 i=a002 p=0012",
               fetch_stall, instruct, pc2_out);
    end
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "skid_drain");
  endtask

  task automatic test_flush;
    cyc(1'b1, 16'hB001, 16'h0020, 1'b0, 1'b0, "flush_fill");
    cyc(1'b1, 16'hB002, 16'h0022, 1'b1, 1'b0, "flush_skid");
    cyc(1'b1, 16'hB003, 16'h0024, 1'b1, 1'b1, "flush_do");
    checks++;
    if (valid !== 1'b0 || instruct !== 16'h0800 || fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush: got v=%b i=%h fs=%b want v=0 i=0800 fs=0",
               valid, instruct, fetch_stall);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'hC000 + 16'(i), 16'h0100 + 16'(2 * i), 1'b0, 1'b0, "b2b");
      checks++;
      if (valid !== 1'b1 || instruct !== 16'hC000 + 16'(i)) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got v=%b i=%h want v=1 i=%h", i, valid, instruct,
                 16'hC000 + 16'(i));
      end
    end
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "b2b_drain");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
          1'($urandom_range(0, 2) == 0 ? 0 : 1) ^ 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), "random");
    end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 16'hD001, 16'h0030, 1'b0, 1'b0, "mid_fill");
    cyc(1'b1, 16'hD002, 16'h0032, 1'b1, 1'b0, "mid_skid");
    in_valid = 1'b0; id_stall = 1'b1; flush = 1'b0;
    #2;
    rst = 1'b1;
    mq.delete();
    #1;
    checks++;
    if (valid !== 1'b0 || instruct !== 16'h0800 || pc2_out !== 16'h0000 ||
        fetch_stall !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b i=%h p=%h fs=%b e=%b want v=0 i=0800 p=0000 fs=0 e=0",
               valid, instruct, pc2_out, fetch_stall, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_stall = 1'b0;
    cyc(1'b1, 16'hE001, 16'h0040, 1'b0, 1'b0, "post_reset_load");
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_skid();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
